// File: rtl/gnn_aggr_engine.sv
// -----------------------------------------------------------------------------
// gnn_aggr_engine
//
// Time-multiplexed neighbour aggregation for the GNN datapath. A frame of
// N_NODES node feature vectors is streamed in (node 0 first), buffered, and
// for each destination node i the features of every contributing node j are
// summed one neighbour per cycle. The result for each node is then offered
// downstream with valid/ready backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   engine can accept an input beat (IDLE/LOAD)
//   in_feat    one node's features, feature f at [f*IN_W +: IN_W]
//   in_adj     adjacency, bit [i*N_NODES+j] = node j contributes to node i;
//              captured on the node-0 beat only
//   out_valid  aggregated vector valid
//   out_ready  downstream accepts
//   out_aggr   aggregated features of out_node, feature f at [f*AGG_W +: AGG_W]
//   out_node   destination node index
//   out_last   high with out_valid for node N_NODES-1
//   busy       engine is not IDLE
//
// Build option:
//   GNN_AGGR_SELF_LOOP_EN  when defined, diagonal adjacency bits are forced
//                          to 1 as the adjacency is captured, so each node
//                          always aggregates its own features.
// -----------------------------------------------------------------------------
module gnn_aggr_engine #(
    parameter int N_NODES = 4,
    parameter int N_FEAT  = 4,
    parameter int IN_W    = 5,
    // Accumulator width is derived so that N_NODES worst-case values never overflow.
    localparam int AGG_W  = IN_W + $clog2(N_NODES),
    localparam int NW     = $clog2(N_NODES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_FEAT*IN_W-1:0]       in_feat,
    input  logic [N_NODES*N_NODES-1:0]   in_adj,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_FEAT*AGG_W-1:0]      out_aggr,
    output logic [NW-1:0]                out_node,
    output logic                         out_last,
    output logic                         busy
);

    localparam int              AW       = $clog2(N_NODES * N_NODES);
    localparam logic [NW-1:0]   LAST_IDX = NW'(N_NODES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [NW-1:0]                 load_cnt_r;
    logic [NW-1:0]                 i_r;
    logic [NW-1:0]                 j_r;
    logic [N_NODES*N_NODES-1:0]    adj_r;
    logic signed [IN_W-1:0]        feat_r [N_NODES][N_FEAT];
    logic signed [AGG_W-1:0]       acc_r  [N_FEAT];

    logic                          accept_s;
    logic                          deliver_s;
    logic                          last_load_s;
    logic                          last_j_s;
    logic                          last_node_s;
    logic [AW-1:0]                 adj_idx_s;
    logic                          adj_bit_s;
    logic [N_NODES*N_NODES-1:0]    adj_in_s;

    // Sign-extend one input feature to accumulator width.
    function automatic logic signed [AGG_W-1:0] sext_feat(input logic signed [IN_W-1:0] v);
        return {{(AGG_W-IN_W){v[IN_W-1]}}, v};
    endfunction

`ifdef GNN_AGGR_SELF_LOOP_EN
    // Mask with every diagonal (self-loop) position set.
    function automatic logic [N_NODES*N_NODES-1:0] diag_mask();
        logic [N_NODES*N_NODES-1:0] m;
        m = '0;
        for (int k = 0; k < N_NODES; k++) begin
            m[k*N_NODES + k] = 1'b1;
        end
        return m;
    endfunction

    assign adj_in_s = in_adj | diag_mask();
`else
    assign adj_in_s = in_adj;
`endif

    assign accept_s    = in_valid & in_ready;
    assign deliver_s   = out_valid & out_ready;
    assign last_load_s = (load_cnt_r == LAST_IDX);
    assign last_j_s    = (j_r == LAST_IDX);
    assign last_node_s = (i_r == LAST_IDX);
    assign adj_idx_s   = AW'(int'(i_r) * N_NODES + int'(j_r));
    assign adj_bit_s   = adj_r[adj_idx_s];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s && last_load_s) begin
                    state_nxt_s = S_ACC;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_ACC: begin
                if (last_j_s) begin
                    state_nxt_s = S_OUT;
                end else begin
                    state_nxt_s = S_ACC;
                end
            end
            S_OUT: begin
                if (deliver_s) begin
                    if (last_node_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_ACC;
                    end
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from registered state and accumulators.
    // in_ready is additionally gated by rst so it reads 0 during the reset cycle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_aggr  = '0;
        out_node  = '0;
        out_last  = 1'b0;
        busy      = (state_r != S_IDLE);
        case (state_r)
            S_IDLE, S_LOAD: begin
                in_ready = ~rst;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_node  = i_r;
                out_last  = last_node_s;
                for (int f = 0; f < N_FEAT; f++) begin
                    out_aggr[f*AGG_W +: AGG_W] = acc_r[f];
                end
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: feature buffer, adjacency capture, counters and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_r <= '0;
            i_r        <= '0;
            j_r        <= '0;
            adj_r      <= '0;
            for (int n = 0; n < N_NODES; n++) begin
                for (int f = 0; f < N_FEAT; f++) begin
                    feat_r[n][f] <= '0;
                end
            end
            for (int f = 0; f < N_FEAT; f++) begin
                acc_r[f] <= '0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        adj_r      <= adj_in_s;
                        load_cnt_r <= NW'(1);
                        for (int f = 0; f < N_FEAT; f++) begin
                            feat_r[0][f] <= in_feat[f*IN_W +: IN_W];
                        end
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        load_cnt_r <= load_cnt_r + NW'(1);
                        for (int f = 0; f < N_FEAT; f++) begin
                            feat_r[load_cnt_r][f] <= in_feat[f*IN_W +: IN_W];
                        end
                        if (last_load_s) begin
                            i_r <= '0;
                            j_r <= '0;
                            for (int f = 0; f < N_FEAT; f++) begin
                                acc_r[f] <= '0;
                            end
                        end
                    end
                end
                S_ACC: begin
                    // One neighbour j per cycle; non-contributing neighbours add zero.
                    for (int f = 0; f < N_FEAT; f++) begin
                        if (adj_bit_s) begin
                            acc_r[f] <= acc_r[f] + sext_feat(feat_r[j_r][f]);
                        end
                    end
                    if (last_j_s) begin
                        j_r <= '0;
                    end else begin
                        j_r <= j_r + NW'(1);
                    end
                end
                S_OUT: begin
                    if (deliver_s && !last_node_s) begin
                        i_r <= i_r + NW'(1);
                        j_r <= '0;
                        for (int f = 0; f < N_FEAT; f++) begin
                            acc_r[f] <= '0;
                        end
                    end
                end
                default: begin
                    j_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_aggr_engine.sv
module tb_gnn_aggr_engine;

    localparam int N  = 4;
    localparam int F  = 4;
    localparam int IW = 5;
    localparam int AW = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [F*IW-1:0]    in_feat;
    logic [N*N-1:0]     in_adj;
    logic               out_valid;
    logic               out_ready;
    logic [F*AW-1:0]    out_aggr;
    logic [1:0]         out_node;
    logic               out_last;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int deliv  = 0;
    logic [30:0] sb_q[$];

    always #5 clk = ~clk;

    gnn_aggr_engine #(.N_NODES(N), .N_FEAT(F), .IN_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .in_adj    (in_adj),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_aggr  (out_aggr),
        .out_node  (out_node),
        .out_last  (out_last),
        .busy      (busy)
    );

    function automatic logic [27:0] pk(int a, int b, int c, int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    function automatic logic [19:0] pki(int a, int b, int c, int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [30:0] ex(bit last, int node, logic [27:0] ag);
        return {last, 2'(node), ag};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every delivered output beat is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [30:0] got;
            logic [30:0] exp;
            got = {out_last, out_node, out_aggr};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat_unexpected: got %h with empty scoreboard", got);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL out_beat: got last=%0b node=%0d aggr=%h, expected last=%0b node=%0d aggr=%h",
                             got[30], got[29:28], got[27:0], exp[30], exp[29:28], exp[27:0]);
                end
            end
            deliv++;
        end
    end

    task automatic send_beat(input logic [19:0] f, input logic [15:0] a);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_feat  = f;
        in_adj   = a;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a0, input logic [15:0] arest,
                              input logic [19:0] b0, input logic [19:0] b1,
                              input logic [19:0] b2, input logic [19:0] b3);
        send_beat(b0, a0);
        send_beat(b1, arest);
        send_beat(b2, arest);
        send_beat(b3, arest);
    endtask

    // Returns on the clock edge at which delivery number 'target' happens.
    task automatic wait_deliv(input int target);
        int t;
        t = 0;
        while (deliv < target && t < 300) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (deliv < target) begin
            errors++;
            $display("FAIL deliv_timeout: got %0d deliveries expected %0d", deliv, target);
        end
    endtask

    task automatic push_diamond(input int count);
        if (count > 0) sb_q.push_back(ex(1'b0, 0, pk(6, -6, 0, 45)));
        if (count > 1) sb_q.push_back(ex(1'b0, 1, pk(7, -7, 0, 45)));
        if (count > 2) sb_q.push_back(ex(1'b0, 2, pk(8, -8, 0, 45)));
        if (count > 3) sb_q.push_back(ex(1'b1, 3, pk(9, -9, 0, 45)));
    endtask

    task automatic push_full();
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(ex(k == 3, k, pk(-64, -64, -64, -64)));
        end
    endtask

    task automatic send_diamond();
        send_frame(16'hEDB7, 16'hEDB7,
                   pki(1, -1, 0, 15), pki(2, -2, 0, 15),
                   pki(3, -3, 0, 15), pki(4, -4, 0, 15));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_feat   = '0;
        in_adj    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_aggr", 32'(out_aggr), 32'd0);
        chk("rst_out_node_last", 32'({out_node, out_last}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Diamond topology plus first-output latency
        push_diamond(4);
        send_diamond();
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 20) break;
            @(posedge clk);
            n++;
        end
        chk("latency_cycles", 32'(n), 32'd4);
        wait_deliv(4);
        #1;

        // Full adjacency at the negative extreme, with 5 stall cycles on node 0
        out_ready = 1'b0;
        push_full();
        send_frame(16'hFFFF, 16'hFFFF, pki(-16, -16, -16, -16), pki(-16, -16, -16, -16),
                   pki(-16, -16, -16, -16), pki(-16, -16, -16, -16));
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 20) break;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_aggr", 32'(out_aggr), 32'(pk(-64, -64, -64, -64)));
            chk("bp_out_node", 32'(out_node), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_delivered_first_edge", 32'(deliv), 32'd5);
        chk("bp_valid_drops", 32'(out_valid), 32'd0);
        wait_deliv(8);
        #1;

        // Reset during ACC of node 2, then a clean frame
        push_diamond(2);
        send_diamond();
        wait_deliv(10);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        push_diamond(4);
        send_diamond();
        wait_deliv(14);
        #1;

        // Zero-diagonal adjacency; later-beat in_adj changes and in_valid during ACC ignored
`ifdef GNN_AGGR_SELF_LOOP_EN
        sb_q.push_back(ex(1'b0, 0, pk(3, 3, 3, 3)));
        sb_q.push_back(ex(1'b0, 1, pk(2, 2, 2, 2)));
        sb_q.push_back(ex(1'b0, 2, pk(3, 3, 3, 3)));
        sb_q.push_back(ex(1'b1, 3, pk(4, 4, 4, 4)));
`else
        sb_q.push_back(ex(1'b0, 0, pk(2, 2, 2, 2)));
        sb_q.push_back(ex(1'b0, 1, pk(0, 0, 0, 0)));
        sb_q.push_back(ex(1'b0, 2, pk(0, 0, 0, 0)));
        sb_q.push_back(ex(1'b1, 3, pk(0, 0, 0, 0)));
`endif
        send_frame(16'h0002, 16'hFFFF, pki(1, 1, 1, 1), pki(2, 2, 2, 2),
                   pki(3, 3, 3, 3), pki(4, 4, 4, 4));
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_feat  = 20'($urandom);
            in_adj   = 16'($urandom);
            @(negedge clk);
            chk("acc_in_ready_low", 32'(in_ready), 32'd0);
            chk("acc_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_deliv(18);
        #1;

        // Back-to-back: next node-0 beat accepted right after the out_last delivery
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_busy", 32'(busy), 32'd0);
        push_full();
        send_frame(16'hFFFF, 16'hFFFF, pki(-16, -16, -16, -16), pki(-16, -16, -16, -16),
                   pki(-16, -16, -16, -16), pki(-16, -16, -16, -16));
        wait_deliv(22);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
